// File: rtl/magnetron_ctrl_if.sv
// Panel/timer-side and latch-side signals of the magnetron sequencer.
// Master = panel/timer/test driver, slave = magnetron_ctrl.
interface magnetron_ctrl_if;
   logic       start_i;
   logic       stop_i;
   logic       door_closed_i;
   logic       timer_done_i;
   logic       latch_s_o;
   logic       latch_r_o;
   logic       heating_o;
   logic       paused_o;
   logic       done_o;
   logic [1:0] state_o;

   modport master (
      output start_i, stop_i, door_closed_i, timer_done_i,
      input  latch_s_o, latch_r_o, heating_o, paused_o, done_o, state_o
   );

   modport slave (
      input  start_i, stop_i, door_closed_i, timer_done_i,
      output latch_s_o, latch_r_o, heating_o, paused_o, done_o, state_o
   );
endinterface

// File: rtl/magnetron_ctrl.sv
// Magnetron SR-latch sequencer: start/stop/door/timer events -> exclusive S/R commands.
// Optional door-closure debounce is built when DOOR_DEBOUNCE_EN is defined.
//
// state    | meaning
// IDLE     | power off, waiting for start with door closed
// HEATING  | magnetron latch set, cooking
// PAUSED   | door opened mid-cook, hold-off running, restart allowed once expired
// HOLDOFF  | stopped or finished, waiting out the restart hold-off
module magnetron_ctrl #(
   parameter int unsigned HOLDOFF_CYC = 20,
   parameter int unsigned DEB_CYC     = 8,
   parameter int unsigned CNT_W       = 8
) (
   input logic              clk,
   input logic              rst_n,
   magnetron_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_HEATING = 2'b01,
      ST_PAUSED  = 2'b10,
      ST_HOLDOFF = 2'b11
   } state_t;

   localparam int unsigned     CNT_MAX   = (HOLDOFF_CYC > DEB_CYC) ? HOLDOFF_CYC : DEB_CYC;
   localparam logic [CNT_W-1:0] HC_LOAD  = CNT_W'(HOLDOFF_CYC);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   generate
      if (CNT_W < $clog2(CNT_MAX + 1)) begin : g_cnt_w_too_narrow
         $error("magnetron_ctrl: CNT_W cannot hold max(HOLDOFF_CYC, DEB_CYC)");
      end
   endgenerate

   state_t           state_q, state_d;
   logic [CNT_W-1:0] hc_q, hc_d;
   logic             door_meta_q, door_s_q;
   logic             door_ok;
   logic             latch_s_q, latch_s_d;
   logic             latch_r_q, latch_r_d;
   logic             heating_q, heating_d;
   logic             paused_q, paused_d;
   logic             done_q, done_d;

   // Door switch is asynchronous; reset value 0 treats the door as open.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         door_meta_q <= 1'b0;
         door_s_q    <= 1'b0;
      end else begin
         door_meta_q <= bus.door_closed_i;
         door_s_q    <= door_meta_q;
      end
   end

`ifdef DOOR_DEBOUNCE_EN
   localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEB_CYC);
   logic [CNT_W-1:0] deb_q, deb_d;

   always_comb begin
      deb_d = deb_q;
      if (!door_s_q) begin
         deb_d = '0;
      end else if (deb_q != DEB_LIM) begin
         deb_d = deb_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_q <= '0;
      end else begin
         deb_q <= deb_d;
      end
   end

   // Opening is never debounced: door_s_q=0 drops door_ok immediately.
   assign door_ok = door_s_q && (deb_q == DEB_LIM);
`else
   assign door_ok = door_s_q;
`endif

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start_i && door_ok && !bus.timer_done_i) begin
               state_d = ST_HEATING;
            end
         end
         ST_HEATING: begin
            if (!door_s_q) begin
               state_d = ST_PAUSED;
            end else if (bus.stop_i) begin
               state_d = ST_HOLDOFF;
            end else if (bus.timer_done_i) begin
               state_d = ST_HOLDOFF;
               done_d  = 1'b1;
            end
         end
         ST_PAUSED: begin
            if (bus.stop_i) begin
               state_d = ST_HOLDOFF;
            end else if (bus.start_i && door_ok && (hc_q == '0)) begin
               state_d = ST_HEATING;
            end
         end
         ST_HOLDOFF: begin
            if (hc_q == '0) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      hc_d = hc_q;
      if ((state_q == ST_HEATING) && (state_d != ST_HEATING)) begin
         hc_d = HC_LOAD;
      end else if (((state_q == ST_PAUSED) || (state_q == ST_HOLDOFF)) && (hc_q != '0)) begin
         hc_d = hc_q - CNT_ONE;
      end
   end

   // Outputs decoded from the next state so they change on the same edge as the state.
   always_comb begin
      latch_s_d = (state_d == ST_HEATING) && (state_q != ST_HEATING);
      latch_r_d = (state_d != ST_HEATING);
      heating_d = (state_d == ST_HEATING);
      paused_d  = (state_d == ST_PAUSED);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         hc_q      <= '0;
         latch_s_q <= 1'b0;
         latch_r_q <= 1'b1;
         heating_q <= 1'b0;
         paused_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         hc_q      <= hc_d;
         latch_s_q <= latch_s_d;
         latch_r_q <= latch_r_d;
         heating_q <= heating_d;
         paused_q  <= paused_d;
         done_q    <= done_d;
      end
   end

   assign bus.latch_s_o = latch_s_q;
   assign bus.latch_r_o = latch_r_q;
   assign bus.heating_o = heating_q;
   assign bus.paused_o  = paused_q;
   assign bus.done_o    = done_q;
   assign bus.state_o   = state_q;

endmodule

// File: tb/tb_magnetron_ctrl.sv
// Self-checking bench for magnetron_ctrl: vector table, directed corner sequences and
// random stimulus against a timestamp-based reference model.
module tb_magnetron_ctrl;

   localparam int HOLDOFF = 20;
   localparam int DEB     = 8;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   magnetron_ctrl_if bus ();

   magnetron_ctrl #(.HOLDOFF_CYC(HOLDOFF), .DEB_CYC(DEB), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: mode 0=idle 1=heating 2=paused 3=holdoff.
   int  m_mode;
   int  m_edge;
   int  m_exit_edge;
   bit  m_s, m_r, m_done;
   bit  door_hist[$];

   function automatic bit door_s_at(int back);
      int idx;
      idx = door_hist.size() - 2 - back;
      return (idx >= 0) ? door_hist[idx] : 1'b0;
   endfunction

   task automatic model_reset();
      m_mode      = 0;
      m_edge      = 0;
      m_exit_edge = -1000;
      m_s         = 1'b0;
      m_r         = 1'b1;
      m_done      = 1'b0;
      door_hist.delete();
   endtask

   task automatic model_edge(input bit st, input bit sp, input bit dc, input bit td);
      bit ds, ok, expired;
      int prev;
      m_edge  = m_edge + 1;
      ds      = door_s_at(0);
      ok      = ds;
`ifdef DOOR_DEBOUNCE_EN
      for (int j = 0; j <= DEB; j++) ok = ok & door_s_at(j);
`endif
      expired = (m_edge - m_exit_edge) >= HOLDOFF + 1;
      prev    = m_mode;
      m_done  = 1'b0;
      case (m_mode)
         0: if (st && ok && !td) m_mode = 1;
         1: begin
            if (!ds)      m_mode = 2;
            else if (sp)  m_mode = 3;
            else if (td) begin m_mode = 3; m_done = 1'b1; end
         end
         2: begin
            if (sp)                          m_mode = 3;
            else if (st && ok && expired)    m_mode = 1;
         end
         default: if (expired) m_mode = 0;
      endcase
      if (prev == 1 && m_mode != 1) m_exit_edge = m_edge;
      m_s = (m_mode == 1) && (prev != 1);
      m_r = (m_mode != 1);
      door_hist.push_back(dc);
      if (door_hist.size() > 32) void'(door_hist.pop_front());
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         failures = failures + 1;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_model();
      chk("state",   int'(bus.state_o),   m_mode);
      chk("latch_s", int'(bus.latch_s_o), int'(m_s));
      chk("latch_r", int'(bus.latch_r_o), int'(m_r));
      chk("heating", int'(bus.heating_o), int'(m_mode == 1));
      chk("paused",  int'(bus.paused_o),  int'(m_mode == 2));
      chk("done",    int'(bus.done_o),    int'(m_done));
      chk("s_r_excl", int'(bus.latch_s_o & bus.latch_r_o), 0);
   endtask

   task automatic step(input bit st, input bit sp, input bit dc, input bit td);
      bus.start_i       = st;
      bus.stop_i        = sp;
      bus.door_closed_i = dc;
      bus.timer_done_i  = td;
      @(posedge clk);
      model_edge(st, sp, dc, td);
      #1;
      chk_model();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   typedef struct {
      bit       st, sp, dc, td;
      bit [1:0] e_state;
      bit       e_s, e_r, e_done;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(bit st, bit sp, bit dc, bit td, bit [1:0] es, bit s, bit r, bit d);
      vec_t v;
      v.st = st; v.sp = sp; v.dc = dc; v.td = td;
      v.e_state = es; v.e_s = s; v.e_r = r; v.e_done = d;
      return v;
   endfunction

   always @(negedge clk) begin
      if (rst_n && bus.latch_s_o && bus.latch_r_o) begin
         failures = failures + 1;
         $display("FAIL s_r_overlap actual=1 required=0 (t=%0t)", $time);
      end
   end

   int e;

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      bus.start_i = 1'b0; bus.stop_i = 1'b0; bus.door_closed_i = 1'b0; bus.timer_done_i = 1'b0;
      model_reset();

      // T1: reset held with toggling inputs
      for (int i = 0; i < 6; i++) begin
         bus.start_i = 1'(i); bus.stop_i = 1'(i >> 1); bus.door_closed_i = 1'b1; bus.timer_done_i = 1'(i >> 2);
         @(posedge clk);
         #1;
         chk("rst_latch_r", int'(bus.latch_r_o), 1);
         chk("rst_latch_s", int'(bus.latch_s_o), 0);
         chk("rst_state",   int'(bus.state_o),   0);
         chk("rst_done",    int'(bus.done_o),    0);
      end
      rst_n = 1'b1;
      model_reset();

      // T2: normal cook from reset release, expected values as constants
      vecs.push_back(mk(0,0,1,0, 2'b00, 0,1,0));
      vecs.push_back(mk(1,0,1,0, 2'b00, 0,1,0));
`ifdef DOOR_DEBOUNCE_EN
      for (int i = 0; i < DEB; i++) vecs.push_back(mk(0,0,1,0, 2'b00, 0,1,0));
`endif
      vecs.push_back(mk(1,0,1,0, 2'b01, 1,0,0));
      vecs.push_back(mk(1,0,1,0, 2'b01, 0,0,0));
      vecs.push_back(mk(0,0,1,0, 2'b01, 0,0,0));
      vecs.push_back(mk(0,0,1,1, 2'b11, 0,1,1));
      vecs.push_back(mk(1,0,1,0, 2'b11, 0,1,0));
      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].st, vecs[i].sp, vecs[i].dc, vecs[i].td);
         chk($sformatf("vec%0d_state", i), int'(bus.state_o),   int'(vecs[i].e_state));
         chk($sformatf("vec%0d_s", i),     int'(bus.latch_s_o), int'(vecs[i].e_s));
         chk($sformatf("vec%0d_r", i),     int'(bus.latch_r_o), int'(vecs[i].e_r));
         chk($sformatf("vec%0d_done", i),  int'(bus.done_o),    int'(vecs[i].e_done));
      end
      // hold-off: exit edge then 20 edges still in HOLDOFF, IDLE on the 21st
      for (int i = 2; i <= HOLDOFF; i++) begin
         step(1, 0, 1, 0);
         chk("holdoff_stay", int'(bus.state_o), 3);
      end
      step(0, 0, 1, 0);
      chk("holdoff_exit", int'(bus.state_o), 0);

      // T3: door opens mid-cook
      step(1, 0, 1, 0);
      chk("t3_heat", int'(bus.state_o), 1);
      step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      chk("t3_door_lat1", int'(bus.state_o), 1);
      step(0, 0, 1, 0);
      chk("t3_paused", int'(bus.state_o), 2);
      chk("t3_latch_r", int'(bus.latch_r_o), 1);
      for (int k = 1; k <= 21; k++) begin
         step((k == 5) || (k >= 20), 0, 1, 0);
         if (k == 5)  chk("t3_start_early", int'(bus.state_o), 2);
         if (k == 20) chk("t3_start_hc1",   int'(bus.state_o), 2);
         if (k == 21) chk("t3_restart",     int'(bus.state_o), 1);
      end

      // T4a: stop + timer_done together
      step(0, 1, 1, 1);
      chk("t4_stop_td_state", int'(bus.state_o), 3);
      chk("t4_stop_td_done",  int'(bus.done_o),  0);
      e = 0;
      while (bus.state_o != 2'b00 && e < 40) begin step(0, 0, 1, 0); e++; end
      chk("t4_idle_timeout", int'(bus.state_o), 0);

      // T4b: door open + stop seen on the same edge
      step(1, 0, 1, 0);
      chk("t4b_heat", int'(bus.state_o), 1);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      chk("t4_door_stop", int'(bus.state_o), 2);

      // reset asserted mid-HEATING takes effect without a clock edge
      do_reset();
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
`ifdef DOOR_DEBOUNCE_EN
      for (int i = 0; i < DEB; i++) step(0, 0, 1, 0);
`endif
      step(1, 0, 1, 0);
      chk("mid_rst_heat", int'(bus.state_o), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_latch_r", int'(bus.latch_r_o), 1);
      chk("mid_rst_state",   int'(bus.state_o),   0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();

      // T5: random traffic against the model
      begin
         bit dc;
         dc = 1'b1;
         for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 39) == 0) dc = ~dc;
            step($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0, dc, $urandom_range(0, 19) == 0);
         end
      end

`ifdef DOOR_DEBOUNCE_EN
      // T6: bouncing door, start held throughout
      do_reset();
      for (int i = 0; i < 9; i++) begin
         step(1, 0, ((i / 3) % 2) == 0, 0);
         chk("t6_bounce_idle", int'(bus.state_o), 0);
      end
      e = 0;
      while (bus.state_o != 2'b01 && e < 30) begin step(1, 0, 1, 0); e++; end
      chk("t6_accept", int'(bus.state_o), 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
